// File: rtl/glyph_row_serializer.sv
// Glyph row serializer: 2-entry row buffer feeding an MSB-first pixel shifter,
// with a registered colour-mapped pixel output stage and a saturating underrun counter.
module glyph_row_serializer #(
  parameter int unsigned GLYPH_W = 10,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned UCNT_W  = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [GLYPH_W-1:0] ROW_DATA,
  input  logic               LOAD_VALID,
  output logic               LOAD_READY,
  input  logic               PIXEL_EN,
  input  logic               LINE_END,
  input  logic [COLOR_W-1:0] FG_COLOR,
  input  logic [COLOR_W-1:0] BG_COLOR,
  output logic [COLOR_W-1:0] PIXEL_RGB,
  output logic               PIXEL_ON,
  output logic               PIXEL_VALID,
  output logic               UNDERRUN,
  output logic [UCNT_W-1:0]  UNDERRUN_CNT
);

  localparam int unsigned IdxW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(GLYPH_W - 1);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [GLYPH_W-1:0] row_q, row_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [GLYPH_W-1:0] buf_q [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;

  logic push, pop, has_row, cur_bit, underrun_c;

  assign LOAD_READY = !RESET && (count_q < 2'd2);
  assign has_row    = (count_q != 2'd0);
  // A row offered together with LINE_END is discarded.
  assign push       = LOAD_VALID && LOAD_READY && !LINE_END;
  assign cur_bit    = (state_q == StFull) && row_q[idx_q];
  assign underrun_c = PIXEL_EN && (state_q == StEmpty);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (has_row) begin
          pop     = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        if (PIXEL_EN) begin
          if (idx_q == '0) begin
            // Reload on the last pixel so consecutive glyphs have no gap.
            if (has_row) pop = 1'b1;
            else         state_d = StEmpty;
          end else begin
            idx_d = idx_q - IdxW'(1);
          end
        end
      end
      default: state_d = StEmpty;
    endcase
    if (pop) begin
      row_d = buf_q[rd_ptr_q];
      idx_d = IdxLast;
    end
    if (LINE_END) begin
      state_d = StEmpty;
      idx_d   = '0;
      pop     = 1'b0;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q + 2'(push) - 2'(pop);
    if (LINE_END) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StEmpty;
      row_q        <= '0;
      idx_q        <= '0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      PIXEL_RGB    <= '0;
      PIXEL_ON     <= 1'b0;
      PIXEL_VALID  <= 1'b0;
      UNDERRUN     <= 1'b0;
      UNDERRUN_CNT <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      if (push) buf_q[wr_ptr_q] <= ROW_DATA;
      PIXEL_VALID <= PIXEL_EN;
      PIXEL_ON    <= PIXEL_EN && cur_bit;
      PIXEL_RGB   <= (PIXEL_EN && cur_bit) ? FG_COLOR : BG_COLOR;
      UNDERRUN    <= underrun_c;
      if (underrun_c && !(&UNDERRUN_CNT)) UNDERRUN_CNT <= UNDERRUN_CNT + UCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_glyph_row_serializer.sv
// Self-checking bench for glyph_row_serializer: queue-based reference model,
// a hand-derived vector table, directed corner sequences and random traffic.
module tb_glyph_row_serializer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] ROW_DATA = '0;
  logic       LOAD_VALID = 1'b0;
  logic       LOAD_READY;
  logic       PIXEL_EN = 1'b0;
  logic       LINE_END = 1'b0;
  logic [2:0] FG_COLOR = 3'd5;
  logic [2:0] BG_COLOR = 3'd2;
  logic [2:0] PIXEL_RGB;
  logic       PIXEL_ON;
  logic       PIXEL_VALID;
  logic       UNDERRUN;
  logic [7:0] UNDERRUN_CNT;

  glyph_row_serializer #(.GLYPH_W(10), .COLOR_W(3), .UCNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .ROW_DATA(ROW_DATA), .LOAD_VALID(LOAD_VALID),
    .LOAD_READY(LOAD_READY), .PIXEL_EN(PIXEL_EN), .LINE_END(LINE_END),
    .FG_COLOR(FG_COLOR), .BG_COLOR(BG_COLOR), .PIXEL_RGB(PIXEL_RGB), .PIXEL_ON(PIXEL_ON),
    .PIXEL_VALID(PIXEL_VALID), .UNDERRUN(UNDERRUN), .UNDERRUN_CNT(UNDERRUN_CNT)
  );

  always #5 CLK = ~CLK;

  int unsigned nvec = 0;
  int unsigned nfail = 0;

  // Reference model: buffered rows and the remaining pixel bits of the current glyph.
  logic [9:0]  mq[$];
  bit          sq[$];
  int unsigned mcnt;
  logic        ready_s;

  typedef struct {
    logic       v;
    logic [9:0] row;
    logic       pen;
    logic       le;
    logic       e_ready;
    logic       e_valid;
    logic       e_on;
    logic       e_urun;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    LOAD_VALID = 1'b0; PIXEL_EN = 1'b0; LINE_END = 1'b0;
    RESET = 1'b1;
    mq.delete(); sq.delete(); mcnt = 0;
    @(posedge CLK); #1;
    check("rst_ready", LOAD_READY, 0);
    check("rst_valid", PIXEL_VALID, 0);
    check("rst_on", PIXEL_ON, 0);
    check("rst_rgb", PIXEL_RGB, 0);
    check("rst_urun", UNDERRUN, 0);
    check("rst_cnt", UNDERRUN_CNT, 0);
    RESET = 1'b0;
  endtask

  // One clock cycle: drive, check READY, step the model, check registered outputs.
  task automatic cycle(input logic v, input logic [9:0] r, input logic p, input logic le);
    bit         e_ready, e_on, e_urun, was_empty;
    logic [2:0] fg, bg;
    logic [9:0] nr;
    LOAD_VALID = v; ROW_DATA = r; PIXEL_EN = p; LINE_END = le;
    fg = FG_COLOR; bg = BG_COLOR;
    e_ready = (mq.size() < 2);
    @(negedge CLK);
    ready_s = LOAD_READY;
    check("ready", LOAD_READY, e_ready);
    @(posedge CLK);
    was_empty = (sq.size() == 0);
    e_on   = p && !was_empty && sq[0];
    e_urun = p && was_empty;
    if (p && !was_empty) void'(sq.pop_front());
    if (le) begin
      mq.delete(); sq.delete();
    end else begin
      if (sq.size() == 0 && mq.size() > 0) begin
        nr = mq.pop_front();
        for (int i = 9; i >= 0; i--) sq.push_back(nr[i]);
      end
      if (v && e_ready) mq.push_back(r);
    end
    if (e_urun && mcnt < 255) mcnt++;
    #1;
    check("valid", PIXEL_VALID, p);
    check("on", PIXEL_ON, e_on);
    check("rgb", PIXEL_RGB, e_on ? fg : bg);
    check("urun", UNDERRUN, e_urun);
    check("ucnt", UNDERRUN_CNT, mcnt);
  endtask

  initial begin
    int         ones_a, ones_b, urun_seen;
    logic [9:0] pat;

    do_reset();

    // Table: one row 10'h201 pushed into an idle block, then drained plus one underrun.
    pat = 10'b1000000001;
    tbl[0] = '{1'b1, 10'h201, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++)
      tbl[2+i] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1, pat[9-i], 1'b0};
    tbl[12] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].row, tbl[i].pen, tbl[i].le);
      check("tbl_ready", ready_s, tbl[i].e_ready);
      check("tbl_valid", PIXEL_VALID, tbl[i].e_valid);
      check("tbl_on", PIXEL_ON, tbl[i].e_on);
      check("tbl_rgb", PIXEL_RGB, tbl[i].e_on ? 3'd5 : 3'd2);
      check("tbl_urun", UNDERRUN, tbl[i].e_urun);
    end

    // Back-to-back glyphs 3FF then 000: 20 pixels with no bubble.
    do_reset();
    cycle(1, 10'h3FF, 0, 0);
    cycle(1, 10'h000, 0, 0);
    ones_a = 0; ones_b = 0; urun_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 10'h0, 1, 0);
      if (i < 10) ones_a += int'(PIXEL_ON);
      else        ones_b += int'(PIXEL_ON);
      urun_seen += int'(UNDERRUN);
    end
    check("b2b_ones_first", ones_a, 10);
    check("b2b_ones_second", ones_b, 0);
    check("b2b_no_underrun", urun_seen, 0);

    // Fill: three accepts, then READY low and a fourth row ignored.
    do_reset();
    cycle(1, 10'h155, 0, 0);
    cycle(1, 10'h2AA, 0, 0);
    cycle(1, 10'h0F0, 0, 0);
    cycle(1, 10'h3C3, 0, 0);
    check("full_ready_low", ready_s, 0);
    for (int i = 0; i < 32; i++) cycle(0, 10'h0, 1, 0);

    // Underruns with nothing loaded.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 10'h0, 1, 0);
    check("urun_cnt3", UNDERRUN_CNT, 3);

    // LINE_END mid-row with two rows buffered.
    do_reset();
    cycle(1, 10'h3FF, 0, 0);
    cycle(1, 10'h3FF, 0, 0);
    cycle(1, 10'h3FF, 0, 0);
    cycle(1, 10'h3FF, 1, 0);
    cycle(1, 10'h3FF, 1, 1);
    check("le_pixel_out", PIXEL_ON, 1);
    cycle(0, 10'h0, 0, 0);
    check("le_ready_after", ready_s, 1);
    cycle(0, 10'h0, 1, 0);
    check("le_then_underrun", UNDERRUN, 1);

    // Async reset in the middle of a shift.
    do_reset();
    cycle(1, 10'h3FF, 0, 0);
    cycle(0, 10'h0, 0, 0);
    cycle(0, 10'h0, 1, 0);
    cycle(0, 10'h0, 1, 0);
    #3 RESET = 1'b1;
    #1;
    check("async_valid", PIXEL_VALID, 0);
    check("async_on", PIXEL_ON, 0);
    check("async_rgb", PIXEL_RGB, 0);
    check("async_ready", LOAD_READY, 0);
    do_reset();
    for (int i = 0; i < 260; i++) cycle(0, 10'h0, 1, 0);
    check("ucnt_saturated", UNDERRUN_CNT, 8'hFF);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      FG_COLOR = 3'($urandom_range(0, 7));
      BG_COLOR = 3'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), 10'($urandom), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
